hazard_unit_sb: RTL

Parametrised hazard control unit for the 5-stage in-order core, extended with a register scoreboard for variable-latency (multi-cycle) execution units such as a divider. It keeps MEM/WB forwarding, load-use stalling and mispredict flushing. It adds x0-aware hazard detection, RAW and WAW tracking on in-flight multi-cycle writes, an outstanding-operation limit, and a saturating stall-cycle counter. It sits beside the pipeline registers and drives their stall/flush enables and the EXEC-stage operand muxes.

---
 rtl/hazard_unit_sb.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hazard_unit_sb.sv
// Hazard control for the 5-stage core: forwarding, load-use and mispredict handling,
// plus a register scoreboard tracking in-flight multi-cycle results.
module hazard_unit_sb #(
    parameter int REG_ADDR_W  = 5,
    parameter int MC_MAX_OUT  = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_arstn,
    input  logic [REG_ADDR_W-1:0]   i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0]   i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr_dec,
    input  logic [REG_ADDR_W-1:0]   i_rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0]   i_rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr_exec,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr_mem,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr_wb,
    input  logic                    i_reg_we_mem,
    input  logic                    i_reg_we_wb,
    input  logic                    i_load_instr_exec,
    input  logic                    i_branch_mispred_exec,
    input  logic                    i_stall_cache,
    input  logic                    i_mc_instr_dec,
    input  logic                    i_mc_issue_exec,
    input  logic                    i_mc_done,
    input  logic [REG_ADDR_W-1:0]   i_mc_done_rd,
    output logic                    o_stall_fetch,
    output logic                    o_stall_dec,
    output logic                    o_stall_exec,
    output logic                    o_stall_mem,
    output logic                    o_flush_dec,
    output logic                    o_flush_exec,
    output logic [1:0]              o_forward_rs1,
    output logic [1:0]              o_forward_rs2,
    output logic [2**REG_ADDR_W-1:0] o_mc_busy,
    output logic                    o_mc_full,
    output logic                    o_sb_err,
    output logic [STALL_CNT_W-1:0]  o_stall_cnt
);

    localparam int NREG  = 2**REG_ADDR_W;
    localparam int CNT_W = $clog2(MC_MAX_OUT + 1);

    localparam logic [REG_ADDR_W-1:0]  ADDR_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [NREG-1:0]        VEC_ZERO  = {NREG{1'b0}};
    localparam logic [NREG-1:0]        VEC_ONE   = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]       CNT_MAX   = CNT_W'(MC_MAX_OUT);
    localparam logic [STALL_CNT_W-1:0] SC_ZERO   = {STALL_CNT_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] SC_ONE    = STALL_CNT_W'(1'b1);
    localparam logic [STALL_CNT_W-1:0] SC_MAX    = {STALL_CNT_W{1'b1}};

    logic [NREG-1:0]        r_busy;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sb_err;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_issue_eff;
    logic                   w_ld_stall;
    logic                   w_sb_stall;
    logic                   w_mc_full;
    logic                   w_front_stall;
    logic                   w_done_ok;
    logic                   w_issue_ok;
    logic                   w_err_evt;
    logic [NREG-1:0]        w_set_mask;
    logic [NREG-1:0]        w_clr_mask;
    logic [NREG-1:0]        w_busy_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_mem,
        input logic                  we_mem,
        input logic [REG_ADDR_W-1:0] rd_wb,
        input logic                  we_wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != ADDR_ZERO && we_mem && rs == rd_mem) begin
            sel = 2'b10;
        end else if (rs != ADDR_ZERO && we_wb && rs == rd_wb) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // A DEC register is hazardous if busy now or being claimed by this cycle's issue.
    function automatic logic reg_hazard(
        input logic [REG_ADDR_W-1:0] r,
        input logic [NREG-1:0]       busy,
        input logic                  issue,
        input logic [REG_ADDR_W-1:0] rd_exec
    );
        return (r != ADDR_ZERO) && (busy[r] || (issue && r == rd_exec));
    endfunction

    assign o_forward_rs1 = fwd_sel(i_rs1_addr_exec, i_rd_addr_mem, i_reg_we_mem, i_rd_addr_wb, i_reg_we_wb);
    assign o_forward_rs2 = fwd_sel(i_rs2_addr_exec, i_rd_addr_mem, i_reg_we_mem, i_rd_addr_wb, i_reg_we_wb);

    assign w_issue_eff = i_mc_issue_exec & ~i_stall_cache & (i_rd_addr_exec != ADDR_ZERO);
    assign w_mc_full   = (r_cnt == CNT_MAX);

    assign w_ld_stall = i_load_instr_exec & (i_rd_addr_exec != ADDR_ZERO) &
                        ((i_rs1_addr_dec == i_rd_addr_exec) | (i_rs2_addr_dec == i_rd_addr_exec));

    assign w_sb_stall = reg_hazard(i_rs1_addr_dec, r_busy, w_issue_eff, i_rd_addr_exec) |
                        reg_hazard(i_rs2_addr_dec, r_busy, w_issue_eff, i_rd_addr_exec) |
                        reg_hazard(i_rd_addr_dec,  r_busy, w_issue_eff, i_rd_addr_exec) |
                        (i_mc_instr_dec & w_mc_full);

    assign w_front_stall = w_ld_stall | w_sb_stall | i_stall_cache;
    assign o_stall_fetch = w_front_stall;
    assign o_stall_dec   = w_front_stall;
    assign o_stall_exec  = i_stall_cache;
    assign o_stall_mem   = i_stall_cache;
    assign o_flush_dec   = i_branch_mispred_exec & ~i_stall_cache;
    assign o_flush_exec  = ((w_ld_stall | w_sb_stall) & ~i_stall_cache) | o_flush_dec;

    // A retire that frees a slot (or the very register) lets a same-cycle issue through.
    assign w_done_ok  = i_mc_done & (r_cnt != CNT_ZERO) & r_busy[i_mc_done_rd];
    assign w_issue_ok = w_issue_eff & (~w_mc_full | w_done_ok) &
                        (~r_busy[i_rd_addr_exec] | (w_done_ok & (i_mc_done_rd == i_rd_addr_exec)));
    assign w_err_evt  = (i_mc_done & ~w_done_ok) | (w_issue_eff & ~w_issue_ok);

    assign w_clr_mask = w_done_ok  ? (VEC_ONE << i_mc_done_rd)   : VEC_ZERO;
    assign w_set_mask = w_issue_ok ? (VEC_ONE << i_rd_addr_exec) : VEC_ZERO;
    assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~VEC_ONE;

    // Outstanding-operation count next value.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_issue_ok, w_done_ok})
            2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Scoreboard, count and sticky error state.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_busy   <= VEC_ZERO;
            r_cnt    <= CNT_ZERO;
            r_sb_err <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sb_err <= r_sb_err | w_err_evt;
        end
    end

    // Saturating count of cycles the front end is held.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_stall_cnt <= SC_ZERO;
        end else if (w_front_stall && r_stall_cnt != SC_MAX) begin
            r_stall_cnt <= r_stall_cnt + SC_ONE;
        end
    end

    assign o_mc_busy   = r_busy;
    assign o_mc_full   = w_mc_full;
    assign o_sb_err    = r_sb_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule
